nibble_serializer: RTL and testbench

Downstream stage for the 4-bit combinational nibble block. It accepts that block's 4-bit output through a valid/ready handshake and buffers up to two nibbles in a small FIFO. Each nibble is then shifted out MSB-first as a 1-bit stream with per-bit valid and end-of-nibble markers. The block lets a parallel combinational result feed a narrow serial consumer, such as an LED or a debug pin, without losing back-to-back results.

---
 rtl/nibble_serializer_if.sv | 35 +++
 rtl/nibble_serializer.sv | 121 ++++++++++++
 tb/tb_nibble_serializer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serializer_if.sv
// Handshake and serial-stream bundle between a nibble producer, the
// serializer and its serial consumer.
interface nibble_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  // Producer/observer side: drives the parallel word, watches the stream.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  ser_out,
    input  ser_valid,
    input  ser_last,
    input  busy
  );

  // Serializer side.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output ser_out,
    output ser_valid,
    output ser_last,
    output busy
  );
endinterface

// File: rtl/nibble_serializer.sv
// Parallel-to-serial converter: a small FIFO buffers incoming words and a
// shifter emits each one MSB-first, one bit per cycle, with no gap between
// consecutive buffered words.
module nibble_serializer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  nibble_serializer_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] fifo_q [DEPTH];
  logic             push;
  logic             pop;
  logic             fifo_nonempty;

  // Ready looks only at the registered count, so a same-cycle pop never
  // opens the door early.
  assign bus.in_ready   = !reset && (count_q != FULL);
  assign push           = bus.in_valid && bus.in_ready;
  assign fifo_nonempty  = (count_q != '0);

  // Next-state and shifter control; a pop always reloads the shifter.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = SHIFT;
          bcnt_d  = '0;
          shift_d = fifo_q[rd_ptr_q];
        end
      end
      SHIFT: begin
        if (bcnt_q != LAST_BIT) begin
          shift_d = shift_q << 1;
          bcnt_d  = bcnt_q + 1'b1;
        end else if (fifo_nonempty) begin
          // Chain straight into the next word without an idle cycle.
          pop     = 1'b1;
          bcnt_d  = '0;
          shift_d = fifo_q[rd_ptr_q];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control and shifter registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.ser_out   = shift_q[WIDTH-1];
  assign bus.ser_valid = (state_q == SHIFT);
  assign bus.ser_last  = (state_q == SHIFT) && (bcnt_q == LAST_BIT);
  assign bus.busy      = (state_q == SHIFT) || fifo_nonempty;
endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench for nibble_serializer: table-driven single words,
// hand-written multi-cycle corner cases, then randomized traffic, all
// compared against a queue-based behavioural model.
module tb_nibble_serializer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nibble_serializer_if #(.WIDTH(W)) bus ();

  nibble_serializer #(.WIDTH(W), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: queue of buffered words plus the word being emitted.
  logic [3:0] mq[$];
  logic [3:0] m_word;
  int         m_bc;
  bit         m_active;
  bit         last_push;

  // Observed stream capture.
  logic [15:0] obits;
  logic [15:0] olast;
  int          ocnt;
  int          cyc;
  int          first_cyc;
  int          last_cyc;

  typedef struct {
    logic [3:0] word;
    logic [3:0] bits;
    logic [3:0] last;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check ready before the edge, advance the model, then
  // compare the registered outputs just after the edge.
  task automatic step();
    bit m_rdy;
    bit had;
    #1;
    m_rdy = !reset && (mq.size() != 2);
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    last_push = (bus.in_valid === 1'b1) && m_rdy;
    @(posedge clk);
    cyc++;
    if (reset) begin
      mq.delete();
      m_active = 1'b0;
      m_bc     = 0;
    end else begin
      had = (mq.size() != 0);
      if (m_active && m_bc < 3) begin
        m_bc++;
      end else if (had) begin
        m_word   = mq.pop_front();
        m_bc     = 0;
        m_active = 1'b1;
      end else begin
        m_active = 1'b0;
      end
      if (last_push) mq.push_back(bus.in_data);
    end
    #1;
    chk("ser_valid", 32'(bus.ser_valid), 32'(m_active));
    chk("ser_last", 32'(bus.ser_last), 32'(m_active && m_bc == 3));
    chk("busy", 32'(bus.busy), 32'(m_active || mq.size() != 0));
    if (m_active) chk("ser_out", 32'(bus.ser_out), 32'(m_word[3-m_bc]));
    if (bus.ser_valid === 1'b1) begin
      if (ocnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      obits = {obits[14:0], bus.ser_out};
      olast = {olast[14:0], bus.ser_last};
      ocnt++;
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic push_word(input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    obits = '0;
    olast = '0;
    ocnt  = 0;
  endtask

  initial begin
    logic [3:0] wlist[4];
    int acc;
    int rej;
    int guard;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    m_word = '0; m_bc = 0; m_active = 1'b0;
    obits = '0; olast = '0; ocnt = 0; cyc = 0; first_cyc = 0; last_cyc = 0;

    tbl[0] = '{word: 4'b1010, bits: 4'b1010, last: 4'b0001};
    tbl[1] = '{word: 4'b0101, bits: 4'b0101, last: 4'b0001};
    tbl[2] = '{word: 4'b1111, bits: 4'b1111, last: 4'b0001};
    tbl[3] = '{word: 4'b0000, bits: 4'b0000, last: 4'b0001};
    tbl[4] = '{word: 4'b1001, bits: 4'b1001, last: 4'b0001};

    // Reset values.
    do_reset();
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_ser_out", 32'(bus.ser_out), 32'd0);
    chk("rst_ser_valid", 32'(bus.ser_valid), 32'd0);
    chk("rst_ser_last", 32'(bus.ser_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // Single words from the table: valid for exactly 4 cycles after E1.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      push_word(tbl[i].word);
      step();
      for (int k = 0; k < 4; k++) begin
        chk("tbl_valid", 32'(bus.ser_valid), 32'd1);
        chk("tbl_bit", 32'(bus.ser_out), 32'(tbl[i].bits[3-k]));
        chk("tbl_last", 32'(bus.ser_last), 32'(tbl[i].last[3-k]));
        step();
      end
      chk("tbl_end_valid", 32'(bus.ser_valid), 32'd0);
      chk("tbl_end_busy", 32'(bus.busy), 32'd0);
    end

    // Back-to-back F then 0: 8 contiguous bits.
    do_reset();
    push_word(4'hF);
    push_word(4'h0);
    idle(12);
    chk("b2b_count", ocnt, 8);
    chk("b2b_bits", 32'(obits[7:0]), 32'h0F0);
    chk("b2b_last", 32'(olast[7:0]), 32'b00010001);
    chk("b2b_contig", last_cyc - first_cyc, 7);

    // Backpressure: 1..4 offered with valid held high.
    do_reset();
    wlist[0] = 4'h1; wlist[1] = 4'h2; wlist[2] = 4'h3; wlist[3] = 4'h4;
    acc = 0; rej = 0; guard = 0;
    bus.in_valid = 1'b1;
    while (acc < 4 && guard < 40) begin
      bus.in_data = wlist[acc];
      step();
      if (last_push) acc++;
      else rej++;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    chk("bp_rejects", rej, 3);
    idle(20);
    chk("bp_count", ocnt, 16);
    chk("bp_stream", 32'(obits), 32'h1234);

    // Ignored push while full.
    do_reset();
    push_word(4'hA);
    push_word(4'hB);
    push_word(4'hC);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h9;
    repeat (3) begin
      step();
      chk("ign_rejected", 32'(last_push), 32'd0);
    end
    bus.in_valid = 1'b0;
    idle(20);
    chk("ign_count", ocnt, 12);
    chk("ign_stream", 32'(obits[11:0]), 32'hABC);

    // Reset after two bits of 1100 with another word queued.
    do_reset();
    push_word(4'b1100);
    push_word(4'h5);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.ser_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    idle(12);
    chk("mid_rst_count", ocnt, 2);
    chk("mid_rst_bits", 32'(obits[1:0]), 32'b11);

    // Push on the same edge that the shifter finishes a word (count==1).
    do_reset();
    push_word(4'hA);
    push_word(4'hB);
    idle(3);
    push_word(4'b0110);
    chk("sim_accepted", 32'(last_push), 32'd1);
    #1;
    chk("sim_ready", 32'(bus.in_ready), 32'd1);
    idle(20);
    chk("sim_count", ocnt, 12);
    chk("sim_stream", 32'(obits[11:0]), 32'hAB6);
    chk("sim_last", 32'(olast[11:0]), 32'b000100010001);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = 4'($urandom);
      reset        = ($urandom_range(0, 80) == 0);
      step();
    end
    reset = 1'b0;
    idle(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
